uart_tx_frame: RTL
==================

// Module: uart_tx_frame
// PURPOSE
//  UART transmitter: the transmit end of the link whose receive end samples on the oversampled clock.
//  Accepts one parallel byte per handshake and serialises it onto TX_OUT.
//  Frame is start bit, 8 data bits LSB first, optional parity bit, then stop bit.
//  Runs on the same oversampled clock as the receiver; each bit is held for Prescale clock cycles.
// PARAMETERS
//  DATA_WIDTH  8  payload bits per frame
//  PRSC_WIDTH  6  width of the Prescale input
// PORTS
//  CLK         in   1           oversampled UART clock
//  RST         in   1           asynchronous reset, active-high
//  P_DATA      in   DATA_WIDTH  byte to transmit
//  Data_Valid  in   1           request; a frame is accepted when Data_Valid=1 and Busy=0
//  PAR_EN      in   1           1 = append a parity bit
//  PAR_TYP     in   1           0 = even parity, 1 = odd parity
//  Prescale    in   PRSC_WIDTH  clock cycles per bit
//  TX_OUT      out  1           serial line, registered, idles high
//  Busy        out  1           high while a frame is on the line
// BEHAVIOUR
//  Reset (asynchronous, immediate, also valid mid-frame):
//   - TX_OUT=1, Busy=0, FSM=IDLE.
//   - Bit counter, cycle counter and data shift register clear to 0.
//   - A frame cut off by reset is abandoned and not resumed.
//  FSM states: IDLE -> START -> DATA -> (PARITY if PAR_EN) -> STOP -> IDLE.
//  IDLE:
//   - TX_OUT=1, Busy=0.
//   - On an edge with Data_Valid=1: latch P_DATA, PAR_EN, PAR_TYP and Prescale into frame registers.
//   - Compute parity from the latched byte; go to START.
//   - From that edge onward, TX_OUT=0 and Busy=1 (one-cycle accept latency).
//  Bit timing:
//   - Cycle counter counts 0..P-1, where P is the latched Prescale.
//   - The state or bit advances when the counter reaches P-1.
//   - A latched Prescale of 0 or 1 is treated as P=2.
//  DATA: 8 bits, LSB first; bit index 0..7; leaves after bit 7.
//  PARITY:
//   - Even parity: TX_OUT = XOR of the data bits.
//   - Odd parity: TX_OUT = the inverse of that XOR.
//  STOP: TX_OUT=1 for P cycles; on the last cycle, go to IDLE with Busy=0.
//  Frame length: (10 + PAR_EN) * P cycles of Busy=1.
//  Minimum gap: back-to-back frames have at least one IDLE cycle between them.
//  Input handling:
//   - Data_Valid while Busy=1 is ignored; it is neither queued nor dropped silently into a later frame.
//   - P_DATA, PAR_EN, PAR_TYP and Prescale changes while Busy=1 have no effect on the current frame.
//  No combinational path from any input to any output.
// CONFIGURATION
//  UART_TX_STOP2_EN defined:
//   - Adds input port STOP2 (1 bit), latched at accept.
//   - STOP2=1 sends two stop bits (2P cycles high); frame length becomes (11 + PAR_EN) * P.
//  UART_TX_STOP2_EN undefined:
//   - No STOP2 port; always exactly one stop bit.
// TESTING
//  T1: P=8, PAR_EN=0, P_DATA=0xA5 -> TX_OUT bits 0,1,0,1,0,0,1,0,1,1, each held 8 cycles; Busy high 80 cycles.
//  T2: P=8, PAR_EN=1, PAR_TYP=0, 0xA5 -> parity bit 0, Busy high 88 cycles. PAR_TYP=1 -> parity bit 1.
//  T3: PAR_EN=1, PAR_TYP=0, 0x07 -> parity bit 1. PAR_TYP=1 -> parity bit 0.
//  T4: Data_Valid pulsed with 0x3C at cycle 20 of a 0xA5 frame -> 0xA5 completes intact, 0x3C never sent.
//      Data_Valid held high -> second frame starts one idle cycle after the first STOP.
//  T5: Assert RST at cycle 30 of a frame -> TX_OUT=1 and Busy=0 immediately.
//      After release, IDLE holds until the next Data_Valid.
//  T6: Prescale=0 -> bits last 2 cycles each.
//      With UART_TX_STOP2_EN, STOP2=1, P=8 -> 16 high stop cycles and Busy high 88 cycles.

Source files
------------

// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity, stop bit(s).
// Define UART_TX_STOP2_EN to add the STOP2 input selecting a two-stop-bit frame.
module uart_tx_frame #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PRSC_WIDTH = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [PRSC_WIDTH-1:0] Prescale,
`ifdef UART_TX_STOP2_EN
    input  logic                  STOP2,
`endif
    output logic                  TX_OUT,
    output logic                  Busy
);

    localparam int unsigned BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]            state;
    logic [PRSC_WIDTH-1:0] cyc_cnt;
    logic [PRSC_WIDTH-1:0] last_cyc;
    logic [PRSC_WIDTH-1:0] last_cyc_next;
    logic [BIT_W-1:0]      bit_idx;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  par_en_q;
    logic                  par_bit_q;
    logic                  stop2_q;
    logic                  stop2_in;
    logic                  bit_end;

`ifdef UART_TX_STOP2_EN
    assign stop2_in = STOP2;
`else
    assign stop2_in = 1'b0;
`endif

    // Prescale values below 2 are clamped so every bit lasts at least two cycles.
    always_comb begin
        last_cyc_next = Prescale - PRSC_WIDTH'(1);
        if (Prescale < PRSC_WIDTH'(2)) begin
            last_cyc_next = PRSC_WIDTH'(1);
        end
    end

    assign bit_end = (cyc_cnt == last_cyc);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            TX_OUT    <= 1'b1;
            Busy      <= 1'b0;
            cyc_cnt   <= '0;
            last_cyc  <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    TX_OUT  <= 1'b1;
                    Busy    <= 1'b0;
                    cyc_cnt <= '0;
                    bit_idx <= '0;
                    if (Data_Valid) begin
                        shreg     <= P_DATA;
                        par_en_q  <= PAR_EN;
                        par_bit_q <= (^P_DATA) ^ PAR_TYP;
                        stop2_q   <= stop2_in;
                        last_cyc  <= last_cyc_next;
                        TX_OUT    <= 1'b0;
                        Busy      <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        cyc_cnt <= '0;
                        TX_OUT  <= shreg[0];
                        shreg   <= shreg >> 1;
                        state   <= DATA;
                    end else begin
                        cyc_cnt <= cyc_cnt + PRSC_WIDTH'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cyc_cnt <= '0;
                        if (bit_idx == LAST_BIT) begin
                            bit_idx <= '0;
                            if (par_en_q) begin
                                TX_OUT <= par_bit_q;
                                state  <= PARITY;
                            end else begin
                                TX_OUT <= 1'b1;
                                state  <= STOP;
                            end
                        end else begin
                            bit_idx <= bit_idx + BIT_W'(1);
                            TX_OUT  <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + PRSC_WIDTH'(1);
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        cyc_cnt <= '0;
                        TX_OUT  <= 1'b1;
                        state   <= STOP;
                    end else begin
                        cyc_cnt <= cyc_cnt + PRSC_WIDTH'(1);
                    end
                end
                STOP: begin
                    // bit_idx is reused to mark the second stop bit of a two-stop frame.
                    if (bit_end) begin
                        cyc_cnt <= '0;
                        if (stop2_q && (bit_idx == '0)) begin
                            bit_idx <= BIT_W'(1);
                        end else begin
                            bit_idx <= '0;
                            TX_OUT  <= 1'b1;
                            Busy    <= 1'b0;
                            state   <= IDLE;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + PRSC_WIDTH'(1);
                    end
                end
                default: begin
                    TX_OUT <= 1'b1;
                    Busy   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule
